// File: rtl/vram_wr_scheduler_if.sv
// VRAM write-scheduler bus: draw-engine write stream, scanout request and RAM port.
// oclip exists only when VRAM_WR_CLIP_EN is defined.
interface vram_wr_scheduler_if #(
  parameter int ADDR_WIDTH    = 19,
  parameter int DATA_WIDTH    = 8,
  parameter int FF_ADDR_WIDTH = 4
);
  logic [ADDR_WIDTH-1:0]  iaddr;
  logic [DATA_WIDTH-1:0]  idata;
  logic                   iwren;
  logic                   oready;
  logic                   scan_next;
  logic [ADDR_WIDTH-1:0]  scan_addr;
  logic [ADDR_WIDTH-1:0]  oaddr;
  logic [DATA_WIDTH-1:0]  odata;
  logic                   owren;
  logic [FF_ADDR_WIDTH:0] olevel;
  logic                   ooverflow;
  logic                   oidle;
`ifdef VRAM_WR_CLIP_EN
  logic                   oclip;
`endif

  modport slave (
    input  iaddr, idata, iwren, scan_next, scan_addr,
`ifdef VRAM_WR_CLIP_EN
    output oclip,
`endif
    output oready, oaddr, odata, owren, olevel, ooverflow, oidle
  );

  modport master (
    output iaddr, idata, iwren, scan_next, scan_addr,
`ifdef VRAM_WR_CLIP_EN
    input  oclip,
`endif
    input  oready, oaddr, odata, owren, olevel, ooverflow, oidle
  );
endinterface

// File: rtl/vram_wr_scheduler.sv
// Buffers draw-engine VRAM writes and commits them only when scanout is not reading.
// Optional address clipping (oclip) is enabled by defining VRAM_WR_CLIP_EN.
//
// state    | meaning
// ST_IDLE  | FIFO empty, RAM port unused
// ST_DRAIN | one FIFO entry written to RAM this cycle
// ST_SCAN  | scanout owns the RAM, oaddr carries the scanout address
module vram_wr_scheduler #(
  parameter int ADDR_WIDTH    = 19,
  parameter int DATA_WIDTH    = 8,
  parameter int FF_ADDR_WIDTH = 4,
  parameter int FF_DEPTH      = 16,
  parameter int AFULL_LEVEL   = 12
`ifdef VRAM_WR_CLIP_EN
  ,
  parameter logic [ADDR_WIDTH-1:0] ADDR_MAX = 19'd307199
`endif
) (
  input logic clk,
  input logic rst,
  vram_wr_scheduler_if.slave bus
);
  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_DRAIN = 2'd1;
  localparam logic [1:0] ST_SCAN  = 2'd2;

  localparam logic [FF_ADDR_WIDTH:0] DEPTH_L = FF_DEPTH[FF_ADDR_WIDTH:0];
  localparam logic [FF_ADDR_WIDTH:0] AFULL_L = AFULL_LEVEL[FF_ADDR_WIDTH:0];

  logic [ADDR_WIDTH+DATA_WIDTH-1:0] mem [FF_DEPTH];
  logic [FF_ADDR_WIDTH-1:0]         wr_ptr, rd_ptr;
  logic [FF_ADDR_WIDTH:0]           level;
  logic [1:0]                       state, next_state;
  logic [ADDR_WIDTH-1:0]            oaddr_q;
  logic [DATA_WIDTH-1:0]            odata_q;
  logic                             ovf_q;
  logic                             in_ok, push, pop, drop;
  logic [ADDR_WIDTH+DATA_WIDTH-1:0] head;

  assign head = mem[rd_ptr];

`ifdef VRAM_WR_CLIP_EN
  logic clip_q, clip_rej;
  assign clip_rej = bus.iwren & (bus.iaddr > ADDR_MAX);
  assign bus.oclip = clip_q;
`endif

  always_comb begin
`ifdef VRAM_WR_CLIP_EN
    in_ok = bus.iwren & ~clip_rej;
`else
    in_ok = bus.iwren;
`endif
    // scanout always wins the RAM; nothing is popped while it reads
    pop  = ~bus.scan_next & (level != '0);
    push = in_ok & ((level != DEPTH_L) | pop);
    drop = in_ok & (level == DEPTH_L) & ~pop;
    if (bus.scan_next)      next_state = ST_SCAN;
    else if (level != '0)   next_state = ST_DRAIN;
    else                    next_state = ST_IDLE;
  end

  // Storage is not reset: the pointers alone define which entries are valid.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= {bus.iaddr, bus.idata};
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state   <= ST_IDLE;
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      level   <= '0;
      oaddr_q <= '0;
      odata_q <= '0;
      ovf_q   <= 1'b0;
`ifdef VRAM_WR_CLIP_EN
      clip_q  <= 1'b0;
`endif
    end else begin
      state <= next_state;
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
      if (drop) ovf_q <= 1'b1;
`ifdef VRAM_WR_CLIP_EN
      if (clip_rej) clip_q <= 1'b1;
`endif
      case (next_state)
        ST_SCAN:  oaddr_q <= bus.scan_addr;
        ST_DRAIN: begin
          oaddr_q <= head[ADDR_WIDTH+DATA_WIDTH-1:DATA_WIDTH];
          odata_q <= head[DATA_WIDTH-1:0];
        end
        default: ;
      endcase
    end
  end

  // The write strobe is exactly the registered DRAIN state.
  assign bus.owren     = (state == ST_DRAIN);
  assign bus.oaddr     = oaddr_q;
  assign bus.odata     = odata_q;
  assign bus.olevel    = level;
  assign bus.ooverflow = ovf_q;
  assign bus.oready    = (level < AFULL_L);
  assign bus.oidle     = (level == '0) & (state != ST_DRAIN);
endmodule

// File: tb/tb_vram_wr_scheduler.sv
// Scoreboard bench for vram_wr_scheduler: expected RAM writes are queued when driven
// and checked in order when owren pulses.
module tb_vram_wr_scheduler;
  logic clk = 1'b0;
  logic rst = 1'b0;
  int total = 0;
  int bad   = 0;
  logic [26:0] exp_q[$];
  logic [26:0] exp_e;

  vram_wr_scheduler_if bus ();
  vram_wr_scheduler dut (.clk(clk), .rst(rst), .bus(bus));

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.iaddr = '0; bus.idata = '0; bus.iwren = 1'b0;
    bus.scan_next = 1'b0; bus.scan_addr = '0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst = 1'b0;
    tick();
    rst = 1'b1;
    exp_q.delete();
  endtask

  task automatic test_reset();
    idle_inputs();
    rst = 1'b0;
    tick();
    total++;
    if ({bus.oaddr, bus.odata, bus.owren, bus.ooverflow, bus.olevel} !== 33'd0) begin
      bad++; $display("FAIL reset_outputs got addr=%0d data=%0h wren=%b ovf=%b lvl=%0d want all 0",
                      bus.oaddr, bus.odata, bus.owren, bus.ooverflow, bus.olevel);
    end
    total++;
    if ({bus.oready, bus.oidle} !== 2'b11) begin
      bad++; $display("FAIL reset_ready_idle got ready=%b idle=%b want 1 1", bus.oready, bus.oidle);
    end
    rst = 1'b1;
    exp_q.delete();
  endtask

  task automatic test_single_write();
    do_reset();
    bus.iaddr = 19'd100; bus.idata = 8'h2A; bus.iwren = 1'b1;
    exp_q.push_back({19'd100, 8'h2A});
    tick();
    bus.iwren = 1'b0;
    total++;
    if (bus.owren !== 1'b0) begin bad++; $display("FAIL single_c1 owren got %b want 0", bus.owren); end
    tick();
    total++;
    exp_e = (exp_q.size() != 0) ? exp_q.pop_front() : 27'h7ffffff;
    if (bus.owren !== 1'b1 || {bus.oaddr, bus.odata} !== exp_e) begin
      bad++; $display("FAIL single_c2 got wren=%b addr=%0d data=%0h want 1 %0d %0h",
                      bus.owren, bus.oaddr, bus.odata, exp_e[26:8], exp_e[7:0]);
    end
    tick();
    total++;
    if (bus.owren !== 1'b0 || bus.oidle !== 1'b1) begin
      bad++; $display("FAIL single_c3 got wren=%b idle=%b want 0 1", bus.owren, bus.oidle);
    end
  endtask

  task automatic test_scan_priority();
    int nw = 0, pulses = 0, first = -1, last = -1;
    logic ok = 1'b1;
    do_reset();
    for (int i = 0; i < 20; i++) begin
      bus.scan_next = 1'b1;
      bus.scan_addr = 19'(i);
      bus.iwren = ((i % 4) == 1) && (nw < 5);
      bus.iaddr = 19'(1000 + i); bus.idata = 8'(8'h10 + i);
      if (bus.iwren) begin exp_q.push_back({bus.iaddr, bus.idata}); nw++; end
      tick();
      if (bus.owren !== 1'b0 || bus.oaddr !== 19'(i)) begin
        ok = 1'b0;
        $display("FAIL scan_track cyc=%0d got wren=%b addr=%0d want 0 %0d", i, bus.owren, bus.oaddr, i);
      end
    end
    total++;
    if (!ok) bad++;
    bus.iwren = 1'b0;
    total++;
    if (bus.olevel !== 5'd5) begin bad++; $display("FAIL scan_level got %0d want 5", bus.olevel); end
    bus.scan_next = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (bus.owren === 1'b1) begin
        pulses++; if (first < 0) first = i; last = i;
        total++;
        exp_e = (exp_q.size() != 0) ? exp_q.pop_front() : 27'h7ffffff;
        if ({bus.oaddr, bus.odata} !== exp_e) begin
          bad++; $display("FAIL scan_drain_data got %0d/%0h want %0d/%0h", bus.oaddr, bus.odata, exp_e[26:8], exp_e[7:0]);
        end
      end
    end
    total++;
    if (pulses != 5 || (last - first) != 4) begin
      bad++; $display("FAIL scan_drain_pulses got %0d span %0d want 5 span 4", pulses, last - first);
    end
  endtask

  task automatic test_overflow();
    int mlev = 0, pulses = 0;
    logic ok = 1'b1;
    do_reset();
    bus.scan_next = 1'b1;
    for (int i = 0; i < 17; i++) begin
      bus.iwren = 1'b1; bus.iaddr = 19'(2000 + i); bus.idata = 8'(8'h40 + i);
      if (mlev < 16) begin exp_q.push_back({bus.iaddr, bus.idata}); mlev++; end
      tick();
      if (bus.olevel !== 5'(mlev) || bus.oready !== (mlev < 12) || bus.ooverflow !== (i == 16)) begin
        ok = 1'b0;
        $display("FAIL ovf_step i=%0d got lvl=%0d rdy=%b ovf=%b want %0d %b %b",
                 i, bus.olevel, bus.oready, bus.ooverflow, mlev, (mlev < 12), (i == 16));
      end
    end
    total++;
    if (!ok) bad++;
    bus.iwren = 1'b0; bus.scan_next = 1'b0;
    for (int i = 0; i < 24; i++) begin
      tick();
      if (bus.owren === 1'b1) begin
        pulses++;
        total++;
        exp_e = (exp_q.size() != 0) ? exp_q.pop_front() : 27'h7ffffff;
        if ({bus.oaddr, bus.odata} !== exp_e) begin
          bad++; $display("FAIL ovf_drain_data got %0d/%0h want %0d/%0h", bus.oaddr, bus.odata, exp_e[26:8], exp_e[7:0]);
        end
      end
    end
    total++;
    if (pulses != 16) begin bad++; $display("FAIL ovf_drain_count got %0d want 16", pulses); end
  endtask

  task automatic test_full_push_pop();
    int pulses = 0;
    do_reset();
    bus.scan_next = 1'b1;
    for (int i = 0; i < 16; i++) begin
      bus.iwren = 1'b1; bus.iaddr = 19'(3000 + i); bus.idata = 8'(8'h80 + i);
      exp_q.push_back({bus.iaddr, bus.idata});
      tick();
    end
    bus.scan_next = 1'b0;
    bus.iaddr = 19'd3100; bus.idata = 8'hEE;
    exp_q.push_back({bus.iaddr, bus.idata});
    tick();
    bus.iwren = 1'b0;
    total++;
    if (bus.olevel !== 5'd16 || bus.ooverflow !== 1'b0) begin
      bad++; $display("FAIL full_push got lvl=%0d ovf=%b want 16 0", bus.olevel, bus.ooverflow);
    end
    for (int i = 0; i < 20; i++) begin
      if (bus.owren === 1'b1) begin
        pulses++;
        total++;
        exp_e = (exp_q.size() != 0) ? exp_q.pop_front() : 27'h7ffffff;
        if ({bus.oaddr, bus.odata} !== exp_e) begin
          bad++; $display("FAIL full_drain_data got %0d/%0h want %0d/%0h", bus.oaddr, bus.odata, exp_e[26:8], exp_e[7:0]);
        end
      end
      tick();
    end
    total++;
    if (pulses != 17) begin bad++; $display("FAIL full_drain_count got %0d want 17", pulses); end
  endtask

  task automatic test_reset_mid_drain();
    logic ok = 1'b1;
    do_reset();
    bus.scan_next = 1'b1;
    for (int i = 0; i < 8; i++) begin
      bus.iwren = 1'b1; bus.iaddr = 19'(4000 + i); bus.idata = 8'(8'hC0 + i);
      tick();
    end
    bus.iwren = 1'b0; bus.scan_next = 1'b0;
    tick(); tick(); tick();
    rst = 1'b0;
    tick();
    total++;
    if (bus.owren !== 1'b0 || bus.olevel !== 5'd0 || bus.oaddr !== 19'd0 || bus.ooverflow !== 1'b0) begin
      bad++; $display("FAIL mid_reset got wren=%b lvl=%0d addr=%0d ovf=%b want 0 0 0 0",
                      bus.owren, bus.olevel, bus.oaddr, bus.ooverflow);
    end
    rst = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (bus.owren !== 1'b0) begin ok = 1'b0; $display("FAIL mid_reset_after cyc=%0d owren=%b want 0", i, bus.owren); end
    end
    total++;
    if (!ok) bad++;
  endtask

  task automatic test_random();
    int mlev = 0;
    logic pop_m;
    logic lvl_ok = 1'b1;
    do_reset();
    for (int i = 0; i < 400; i++) begin
      bus.scan_next = ($urandom_range(0, 99) < 40);
      bus.scan_addr = 19'($urandom_range(0, 307199));
      bus.iwren = ($urandom_range(0, 99) < 55);
      bus.iaddr = 19'($urandom_range(0, 307199));
      bus.idata = 8'($urandom_range(0, 255));
      pop_m = !bus.scan_next && (mlev != 0);
      if (bus.iwren && (mlev < 16 || pop_m)) begin
        exp_q.push_back({bus.iaddr, bus.idata});
        mlev++;
      end
      if (pop_m) mlev--;
      tick();
      if (bus.olevel !== 5'(mlev)) begin
        lvl_ok = 1'b0; $display("FAIL rand_level cyc=%0d got %0d want %0d", i, bus.olevel, mlev);
      end
      if (bus.owren === 1'b1) begin
        total++;
        exp_e = (exp_q.size() != 0) ? exp_q.pop_front() : 27'h7ffffff;
        if ({bus.oaddr, bus.odata} !== exp_e) begin
          bad++; $display("FAIL rand_data cyc=%0d got %0d/%0h want %0d/%0h", i, bus.oaddr, bus.odata, exp_e[26:8], exp_e[7:0]);
        end
      end
    end
    total++;
    if (!lvl_ok) bad++;
    idle_inputs();
    for (int i = 0; i < 20; i++) begin
      tick();
      if (bus.owren === 1'b1) begin
        total++;
        exp_e = (exp_q.size() != 0) ? exp_q.pop_front() : 27'h7ffffff;
        if ({bus.oaddr, bus.odata} !== exp_e) begin
          bad++; $display("FAIL rand_tail got %0d/%0h want %0d/%0h", bus.oaddr, bus.odata, exp_e[26:8], exp_e[7:0]);
        end
      end
    end
    total++;
    if (exp_q.size() != 0 || bus.oidle !== 1'b1) begin
      bad++; $display("FAIL rand_leftover got %0d pending idle=%b want 0 1", exp_q.size(), bus.oidle);
    end
  endtask

`ifdef VRAM_WR_CLIP_EN
  task automatic test_clip();
    do_reset();
    bus.scan_next = 1'b1;
    bus.iwren = 1'b1; bus.iaddr = 19'd307200; bus.idata = 8'h11;
    tick();
    total++;
    if (bus.olevel !== 5'd0 || bus.oclip !== 1'b1 || bus.ooverflow !== 1'b0) begin
      bad++; $display("FAIL clip_reject got lvl=%0d clip=%b ovf=%b want 0 1 0", bus.olevel, bus.oclip, bus.ooverflow);
    end
    bus.iaddr = 19'd307199; bus.idata = 8'h22;
    exp_q.push_back({bus.iaddr, bus.idata});
    tick();
    bus.iwren = 1'b0; bus.scan_next = 1'b0;
    total++;
    if (bus.olevel !== 5'd1) begin bad++; $display("FAIL clip_accept lvl got %0d want 1", bus.olevel); end
    tick();
    total++;
    exp_e = (exp_q.size() != 0) ? exp_q.pop_front() : 27'h7ffffff;
    if (bus.owren !== 1'b1 || {bus.oaddr, bus.odata} !== exp_e) begin
      bad++; $display("FAIL clip_write got wren=%b %0d/%0h want 1 %0d/%0h", bus.owren, bus.oaddr, bus.odata, exp_e[26:8], exp_e[7:0]);
    end
  endtask
`endif

  initial begin
    idle_inputs();
    test_reset();
    test_single_write();
    test_scan_priority();
    test_overflow();
    test_full_push_pop();
    test_reset_mid_drain();
    test_random();
`ifdef VRAM_WR_CLIP_EN
    test_clip();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
